// File: rtl/two_of_three_tx_pkg.sv
// two_of_three_tx_pkg: state encodings and 2-of-3 codeword constants shared by the link transmitter and receiver checker
package two_of_three_tx_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, RTZ = 2'd2, ERR = 2'd3} state_t;
  localparam logic [2:0] CW0 = 3'b110;
  localparam logic [2:0] CW1 = 3'b101;
  localparam logic [2:0] CW2 = 3'b011;
  localparam logic [2:0] SPACER = 3'b000;
  function automatic logic [2:0] encode(input logic [1:0] sym);
    return sym == 2'd0 ? CW0 : sym == 2'd1 ? CW1 : sym == 2'd2 ? CW2 : SPACER;
  endfunction
endpackage

// File: rtl/two_of_three_tx_sync2.sv
// two_of_three_tx_sync2: generic 2-flop synchronizer with asynchronous active-high reset
module two_of_three_tx_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic m;
  // shift the asynchronous input through two flops
  always_ff @(posedge clk or posedge rst)
    if (rst) {q, m} <= 2'b00;
    else {q, m} <= {m, d};
endmodule

// File: rtl/two_of_three_tx.sv
// two_of_three_tx: 2-of-3 four-phase RTZ link transmitter; define TWO_OF_THREE_TX_SKID_EN for a one-entry holding register
module two_of_three_tx
  import two_of_three_tx_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W = 8,
  parameter int SENT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_sym,
  input  logic              ack_in,
  output logic [2:0]        code,
  output logic              err,
  input  logic              err_clr,
  output logic              illegal,
  output logic [SENT_W-1:0] sent_cnt
);
  state_t state, state_nxt;
  logic ack_s, accept, legal, tmo, hold_v;
  logic [1:0] hold_sym;
  logic [CNT_W-1:0] cnt;
  logic [2:0] code_nxt;
  two_of_three_tx_sync2 u_ack_sync (.clk(clk), .rst(rst), .d(ack_in), .q(ack_s));
  assign accept = in_valid && in_ready;
  assign legal = in_sym != 2'd3;
  assign tmo = cnt == CNT_W'(TIMEOUT_CYCLES - 1);
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  // next state: an ack edge in the timeout cycle takes priority over the error
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: state_nxt = accept && legal ? DATA : IDLE;
      DATA: state_nxt = ack_s ? RTZ : tmo ? ERR : DATA;
      RTZ:  state_nxt = !ack_s ? (hold_v ? DATA : IDLE) : tmo ? ERR : RTZ;
      ERR:  state_nxt = err_clr ? RTZ : ERR;
    endcase
  end
  // handshake-facing outputs; in_ready is held low while reset is asserted
  always_comb begin
`ifdef TWO_OF_THREE_TX_SKID_EN
    in_ready = !rst && (state == IDLE ? !ack_s : (state == DATA || state == RTZ) && !hold_v);
`else
    in_ready = !rst && state == IDLE && !ack_s;
`endif
    err = state == ERR;
  end
  // codeword for the next cycle: hold it through DATA, spacer everywhere else
  always_comb
    code_nxt = state_nxt != DATA ? SPACER
             : state == DATA ? code
             : state == RTZ ? encode(hold_sym)
             : encode(in_sym);
  // registered wires, pulse, counters
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      code <= SPACER;
      illegal <= 1'b0;
      sent_cnt <= '0;
      cnt <= '0;
    end else begin
      code <= code_nxt;
      illegal <= accept && !legal;
      sent_cnt <= sent_cnt + SENT_W'(state == RTZ && !ack_s);
      cnt <= state_nxt != state ? '0 : (state == DATA || state == RTZ) ? cnt + 1'b1 : cnt;
    end
`ifdef TWO_OF_THREE_TX_SKID_EN
  // holding register: filled during a handshake, drained on RTZ exit, flushed on error
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hold_v <= 1'b0;
      hold_sym <= 2'd0;
    end else if (state_nxt == ERR || (state == RTZ && state_nxt == DATA)) hold_v <= 1'b0;
    else if (accept && legal && state != IDLE) begin
      hold_v <= 1'b1;
      hold_sym <= in_sym;
    end
`else
  assign hold_v = 1'b0;
  assign hold_sym = 2'd0;
`endif
endmodule
